fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h00000000, meaning first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word address of the pending fetch.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 Instr  output  32  head-of-queue instruction presented to the controller.
REQ-010 InstrPC  output  32  address of Instr.
REQ-011 InstrValid  output  1  Instr/InstrPC are valid.
REQ-012 InstrReady  input  1  controller consumes the head entry this cycle.
REQ-013 PCSrc  input  1  branch redirect strobe from the controller.
REQ-014 BranchTarget  input  32  redirect address, sampled when PCSrc=1.

Function
REQ-015 The FSM SHALL have states IDLE (no request outstanding), REQ (request outstanding), DROP (outstanding request to be discarded).
REQ-016 imem_req and imem_addr SHALL be registered, with imem_req=1 exactly in REQ and DROP; imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-017 At most one memory request SHALL be outstanding.
REQ-018 A new request SHALL be issued (IDLE->REQ, or REQ->REQ on ack) only when the queue count after this cycle's push/pop is below DEPTH, so the queue never overflows.
REQ-019 On imem_ack in REQ with no PCSrc: push {fetch_pc, imem_rdata}, then fetch_pc <= fetch_pc+4 (modulo 2^32, wrap from FFFFFFFC to 00000000).
REQ-020 Back-to-back zero-wait acks SHALL sustain one instruction per cycle when the queue is not full.
REQ-021 The queue SHALL be registered: a word acked in cycle N appears on Instr with InstrValid=1 in cycle N+1 if the queue was empty.
REQ-022 A pop SHALL occur when InstrValid=1 and InstrReady=1; InstrReady with InstrValid=0 SHALL be ignored.
REQ-023 Simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 PCSrc=1 SHALL take priority over push and pop: flush the queue (count=0, InstrValid=0 next cycle) and set fetch_pc <= BranchTarget.
REQ-025 PCSrc=1 in REQ without imem_ack SHALL move to DROP; in DROP the returning ack SHALL be discarded and the FSM SHALL return to REQ at BranchTarget.
REQ-026 PCSrc=1 coincident with imem_ack SHALL discard that word and issue the next request at BranchTarget.
REQ-027 PCSrc=1 in IDLE SHALL go to REQ with imem_addr=BranchTarget next cycle.
REQ-028 PCSrc=1 in DROP SHALL update the pending target only; the outstanding word is still discarded.
REQ-029 Low-order bits [1:0] of BranchTarget SHALL be forced to 0.

Reset
REQ-030 While reset=0: imem_req=0, imem_addr=RESET_PC, InstrValid=0, Instr=0, InstrPC=0, queue empty, fetch_pc=RESET_PC, state IDLE.
REQ-031 Reset asserted mid-request SHALL abandon the request immediately; a late imem_ack after reset release SHALL be ignored unless a new request is outstanding.
REQ-032 First rising edge with reset=1 SHALL enter REQ with imem_addr=RESET_PC.

Verification
REQ-033 Reset release, zero-wait memory returning addr as data, InstrReady=1 -> Instr sequence 0,4,8,... one per cycle, first valid 2 cycles after release.
REQ-034 InstrReady=0, zero-wait memory -> exactly DEPTH (4) words queued, imem_req drops to 0, no overflow; raising InstrReady resumes fetch.
REQ-035 3-cycle memory latency, PCSrc=1 with BranchTarget=0x100 one cycle after request to 0x8 -> word for 0x8 discarded, next imem_addr=0x100, next Instr has InstrPC=0x100.
REQ-036 PCSrc=1 coincident with imem_ack and a pop, queue holding 3 entries -> InstrValid=0 next cycle, acked word dropped, next fetch at target.
REQ-037 fetch_pc=0xFFFFFFFC, ack -> next imem_addr=0x00000000.
REQ-038 reset pulsed low while in DROP -> all outputs at reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Issues at most one outstanding
// word fetch to instruction memory and buffers returned words, tagged with
// their address, in a small FIFO that feeds the controller. A branch redirect
// (PCSrc) flushes the FIFO and retargets the fetch stream. A word already in
// flight when the redirect arrives is dropped when it returns.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state, state_n;

  logic [31:0]      fetch_pc, fetch_pc_n;
  logic [31:0]      addr_n;
  logic [31:0]      target;
  logic             req_n;
  logic             push, pop;
  logic             has_room;
  logic [CNT_W-1:0] count, count_after;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [31:0]      q_instr [DEPTH];
  logic [31:0]      q_pc    [DEPTH];

  // Branch targets are word aligned; the low two bits are ignored.
  assign target = BranchTarget & 32'hFFFF_FFFC;

  // A redirect overrides both push and pop.
  assign InstrValid  = (count != '0);
  assign push        = (state == REQ) && imem_ack && !PCSrc;
  assign pop         = InstrValid && InstrReady && !PCSrc;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);
  assign has_room    = (count_after < CNT_W'(DEPTH));
  assign req_n       = (state_n != IDLE);

  // Head of the queue; forced to zero when empty so nothing stale leaks out.
  assign Instr   = InstrValid ? q_instr[rd_ptr] : '0;
  assign InstrPC = InstrValid ? q_pc[rd_ptr]    : '0;

  // FSM state register; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, next request address and next fetch PC.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = imem_addr;
    case (state)
      IDLE: begin
        if (PCSrc) begin
          state_n    = REQ;
          fetch_pc_n = target;
          addr_n     = target;
        end else if (has_room) begin
          state_n = REQ;
          addr_n  = fetch_pc;
        end
      end
      REQ: begin
        if (PCSrc) begin
          fetch_pc_n = target;
          if (imem_ack) begin
            // Returning word belongs to the old stream: drop it and refetch.
            addr_n = target;
          end else begin
            // Address must stay put until the in-flight word comes back.
            state_n = DROP;
          end
        end else if (imem_ack) begin
          fetch_pc_n = fetch_pc + 32'd4;
          if (has_room) begin
            addr_n = fetch_pc + 32'd4;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DROP: begin
        if (PCSrc) begin
          fetch_pc_n = target;
        end
        if (imem_ack) begin
          // Queue was flushed on entry to DROP, so there is always room.
          state_n = REQ;
          addr_n  = fetch_pc_n;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered memory request and fetch PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      imem_req  <= req_n;
      imem_addr <= addr_n;
      fetch_pc  <= fetch_pc_n;
    end
  end

  // Queue occupancy and pointers; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (PCSrc) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_after;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Queue storage; contents are only observed when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A table of single-cycle
// vectors drives the memory handshake by hand; short scripted sequences use
// a behavioural memory (configurable latency, data = address) for the
// streaming, back-pressure, redirect-latency and reset corner cases.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        PCSrc;
  logic [31:0] BranchTarget;

  // memory model controls
  logic        auto_mem;
  logic        man_ack;
  logic [31:0] man_rdata;
  int          lat;
  int          wcnt;

  int checks;
  int errors;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .PCSrc       (PCSrc),
    .BranchTarget(BranchTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: acks after lat wait cycles, returns the address.
  assign imem_ack   = auto_mem ? (imem_req && (wcnt >= lat)) : man_ack;
  assign imem_rdata = auto_mem ? imem_addr : man_rdata;

  always @(posedge clk or negedge reset) begin
    if (!reset) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic rdy, logic p,
                              logic [31:0] t, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ei, logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.ack = a; v.rdata = d; v.ready = rdy; v.pcsrc = p; v.tgt = t;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic er, input logic [31:0] ea,
                          input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    chk({tag, ".req"},   {31'b0, imem_req},   {31'b0, er});
    chk({tag, ".addr"},  imem_addr,           ea);
    chk({tag, ".valid"}, {31'b0, InstrValid}, {31'b0, ev});
    chk({tag, ".instr"}, Instr,               ei);
    chk({tag, ".pc"},    InstrPC,             ep);
  endtask

  task automatic idle_inputs();
    man_ack = 1'b0; man_rdata = '0; InstrReady = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
  endtask

  // Hold reset for two cycles, then release on a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit found;
    bit bad;
    checks = 0;
    errors = 0;
    auto_mem = 1'b0;
    lat = 0;
    reset = 1'b0;
    idle_inputs();

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    chk_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // ---------------- vector table (manual memory) ----------------
    tbl.push_back(mk(1,0,32'h0,       0,0,32'h0,       1,32'h0,       0,32'h0,       32'h0));
    tbl.push_back(mk(1,1,32'hAAAA0000,0,0,32'h0,       1,32'h4,       1,32'hAAAA0000,32'h0));
    tbl.push_back(mk(1,0,32'h0,       0,0,32'h0,       1,32'h4,       1,32'hAAAA0000,32'h0));
    tbl.push_back(mk(1,1,32'hBBBB0004,1,0,32'h0,       1,32'h8,       1,32'hBBBB0004,32'h4));
    tbl.push_back(mk(1,0,32'h0,       1,0,32'h0,       1,32'h8,       0,32'h0,       32'h0));
    tbl.push_back(mk(1,0,32'h0,       1,0,32'h0,       1,32'h8,       0,32'h0,       32'h0));
    tbl.push_back(mk(1,0,32'h0,       0,1,32'h103,     1,32'h8,       0,32'h0,       32'h0));
    tbl.push_back(mk(1,1,32'hDEAD0008,0,0,32'h0,       1,32'h100,     0,32'h0,       32'h0));
    tbl.push_back(mk(1,1,32'h11110100,0,0,32'h0,       1,32'h104,     1,32'h11110100,32'h100));
    tbl.push_back(mk(1,0,32'h0,       0,1,32'h200,     1,32'h104,     0,32'h0,       32'h0));
    tbl.push_back(mk(1,0,32'h0,       0,1,32'h300,     1,32'h104,     0,32'h0,       32'h0));
    tbl.push_back(mk(1,1,32'hDEAD0104,0,0,32'h0,       1,32'h300,     0,32'h0,       32'h0));
    tbl.push_back(mk(1,0,32'h0,       0,0,32'h0,       1,32'h300,     0,32'h0,       32'h0));
    tbl.push_back(mk(1,1,32'hDEAD0300,0,1,32'h400,     1,32'h400,     0,32'h0,       32'h0));
    tbl.push_back(mk(1,1,32'h44440400,0,0,32'h0,       1,32'h404,     1,32'h44440400,32'h400));
    tbl.push_back(mk(1,1,32'h44440404,0,0,32'h0,       1,32'h408,     1,32'h44440400,32'h400));
    tbl.push_back(mk(1,1,32'h44440408,0,0,32'h0,       1,32'h40C,     1,32'h44440400,32'h400));
    tbl.push_back(mk(1,1,32'h5555040C,1,1,32'h800,     1,32'h800,     0,32'h0,       32'h0));
    tbl.push_back(mk(1,1,32'h66660800,0,0,32'h0,       1,32'h804,     1,32'h66660800,32'h800));
    tbl.push_back(mk(1,1,32'hDEAD0804,0,1,32'hFFFFFFFF,1,32'hFFFFFFFC,0,32'h0,       32'h0));
    tbl.push_back(mk(1,1,32'h77777777,0,0,32'h0,       1,32'h0,       1,32'h77777777,32'hFFFFFFFC));
    tbl.push_back(mk(1,0,32'h0,       0,1,32'h500,     1,32'h0,       0,32'h0,       32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst_n;
      man_ack = tbl[i].ack;
      man_rdata = tbl[i].rdata;
      InstrReady = tbl[i].ready;
      PCSrc = tbl[i].pcsrc;
      BranchTarget = tbl[i].tgt;
      @(negedge clk);
      chk_outs($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
               tbl[i].e_instr, tbl[i].e_pc);
    end

    // ---------------- reset pulsed while in DROP ----------------
    idle_inputs();
    #2 reset = 1'b0;
    #1 chk_outs("drop_rst_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    man_ack = 1'b1;                 // late ack from the abandoned request
    man_rdata = 32'hDEADBEEF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_outs("drop_rst_late_ack", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    man_rdata = 32'h12345678;
    @(negedge clk);
    chk_outs("drop_rst_restart", 1'b1, 32'h4, 1'b1, 32'h12345678, 32'h0);

    // ---------------- zero-wait streaming, InstrReady=1 ----------------
    auto_mem = 1'b1;
    lat = 0;
    pulse_reset();
    InstrReady = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("stream_first_req",   {31'b0, imem_req},   32'h1);
        chk("stream_first_addr",  imem_addr,           32'h0);
        chk("stream_first_valid", {31'b0, InstrValid}, 32'h0);
      end else begin
        chk($sformatf("stream%0d.valid", n), {31'b0, InstrValid}, 32'h1);
        chk($sformatf("stream%0d.instr", n), Instr,   32'(4 * (n - 2)));
        chk($sformatf("stream%0d.pc", n),    InstrPC, 32'(4 * (n - 2)));
      end
    end

    // ---------------- back-pressure: queue fills, fetch stalls ----------------
    pulse_reset();
    InstrReady = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 5) chk("full_req_drop", {31'b0, imem_req}, 32'h0);
    end
    chk_outs("full_hold", 1'b0, 32'hC, 1'b1, 32'h0, 32'h0);
    InstrReady = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("resume_req",  {31'b0, imem_req}, 32'h1);
        chk("resume_addr", imem_addr,         32'h10);
      end
      chk($sformatf("resume%0d.valid", k), {31'b0, InstrValid}, 32'h1);
      chk($sformatf("resume%0d.pc", k),    InstrPC, 32'(4 * k));
      chk($sformatf("resume%0d.instr", k), Instr,   32'(4 * k));
    end

    // ---------------- 3-cycle latency with redirect during request ----------------
    lat = 3;
    pulse_reset();
    InstrReady = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    chk("lat_req8_seen", {31'b0, found}, 32'h1);
    @(negedge clk);
    PCSrc = 1'b1;
    BranchTarget = 32'h100;
    @(negedge clk);
    PCSrc = 1'b0;
    BranchTarget = '0;
    chk("lat_addr_stable", imem_addr, 32'h8);
    chk("lat_req_held", {31'b0, imem_req}, 32'h1);
    found = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (InstrValid && InstrPC == 32'h8) bad = 1'b1;
      if (imem_req && imem_addr == 32'h100) found = 1'b1;
    end
    chk("lat_refetch_target", {31'b0, found}, 32'h1);
    chk("lat_word8_dropped", {31'b0, bad}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (InstrValid) found = 1'b1;
    end
    chk("lat_valid_seen", {31'b0, found}, 32'h1);
    chk("lat_target_pc", InstrPC, 32'h100);
    chk("lat_target_instr", Instr, 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
